// File: rtl/serpent_key_schedule.sv
// rtl/serpent_key_schedule.sv - Serpent 256-bit key expansion streaming round keys K0..K32
module serpent_key_schedule #(
    parameter int          NUM_KEYS = 33,
    parameter logic [31:0] PHI      = 32'h9e3779b9
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [255:0] i_key,
    output logic         o_busy,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_round_key,
    output logic [5:0]   o_round,
    output logic         o_last
);

    localparam logic [5:0] LAST_ROUND = 6'(NUM_KEYS - 1);

    // Serpent S-boxes S0..S7, entry n in nibble n (LSB first).
    localparam logic [63:0] SBOX0 = 64'hC90724DEB56A1F83;
    localparam logic [63:0] SBOX1 = 64'h43D68EB1A50972CF;
    localparam logic [63:0] SBOX2 = 64'h25B04E1DFAC39768;
    localparam logic [63:0] SBOX3 = 64'hE57A421D369C8BF0;
    localparam logic [63:0] SBOX4 = 64'hD7E9A4526B0C38F1;
    localparam logic [63:0] SBOX5 = 64'h176D8E30C9A4B25F;
    localparam logic [63:0] SBOX6 = 64'h0A3DF19EB6485C27;
    localparam logic [63:0] SBOX7 = 64'h6539AC47B28E0FD1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT
    } state_t;

    state_t              state_q, state_d;
    logic [7:0][31:0]    win_q, win_d;
    logic [5:0]          round_q, round_d;
    logic [127:0]        key_q, key_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                last_q, last_d;

    logic [5:0]          step_j;
    logic [7:0]          step_base;
    logic [2:0]          box_sel;
    logic [11:0][31:0]   ext;
    logic [127:0]        step_key;
    logic [7:0][31:0]    step_win;

    function automatic logic [3:0] sbox(input logic [2:0] sel, input logic [3:0] x);
        logic [63:0] tbl;
        case (sel)
            3'd0:    tbl = SBOX0;
            3'd1:    tbl = SBOX1;
            3'd2:    tbl = SBOX2;
            3'd3:    tbl = SBOX3;
            3'd4:    tbl = SBOX4;
            3'd5:    tbl = SBOX5;
            3'd6:    tbl = SBOX6;
            default: tbl = SBOX7;
        endcase
        return tbl[{x, 2'b00} +: 4];
    endfunction

    // One expansion step: the window holds w[4j-8..4j-1]; produce w[4j..4j+3] and Kj.
    always_comb begin
        logic [31:0] t;
        logic [3:0]  nib;
        logic [3:0]  y;
        t         = '0;
        nib       = '0;
        y         = '0;
        step_key  = '0;
        step_j    = (state_q == ST_EMIT) ? round_q + 6'd1 : round_q;
        step_base = {step_j, 2'b00};
        box_sel   = 3'd3 - step_j[2:0];
        ext       = '0;
        ext[7:0]  = win_q;
        for (int k = 0; k < 4; k++) begin
            t = ext[k] ^ ext[k+3] ^ ext[k+5] ^ ext[k+7] ^ PHI ^ {24'd0, step_base + 8'(k)};
            ext[k+8] = {t[20:0], t[31:21]};
        end
        for (int b = 0; b < 32; b++) begin
            nib = {ext[11][b], ext[10][b], ext[9][b], ext[8][b]};
            y   = sbox(box_sel, nib);
            step_key[b]      = y[0];
            step_key[32+b]   = y[1];
            step_key[64+b]   = y[2];
            step_key[96+b]   = y[3];
        end
        step_win = ext[11:4];
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        round_d = round_q;
        key_d   = key_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    win_d   = i_key;
                    round_d = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                state_d = ST_EMIT;
                win_d   = step_win;
                key_d   = step_key;
                round_d = '0;
                valid_d = 1'b1;
                last_d  = 1'b0;
            end
            ST_EMIT: begin
                if (valid_q && i_ready) begin
                    if (round_q == LAST_ROUND) begin
                        // Stream done: scrub key material so nothing lingers in IDLE.
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        key_d   = '0;
                        round_d = '0;
                        win_d   = '0;
                    end else begin
                        win_d   = step_win;
                        key_d   = step_key;
                        round_d = step_j;
                        last_d  = (step_j == LAST_ROUND);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            round_q <= '0;
            key_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            round_q <= round_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign o_busy      = busy_q;
    assign o_valid     = valid_q;
    assign o_round_key = key_q;
    assign o_round     = round_q;
    assign o_last      = last_q;

endmodule
